sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl_pkg.sv | 46 ++++
 rtl/sram_ctrl.sv | 118 +++++++++++
 tb/tb_sram_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM controller: FSM state encoding, SRAM address
// width and the per-state strobe table.
package sram_ctrl_pkg;

  localparam int unsigned SRAM_AW = 20;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD       = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4,
    DONE     = 3'd5
  } state_t;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic dq_oe;
  } strobe_t;

  // Strobe levels a given state presents on the SRAM pins.
  function automatic strobe_t strobes_for(state_t s);
    strobe_t st;
    st = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, dq_oe: 1'b0};
    case (s)
      RD: begin
        st.ce_n = 1'b0;
        st.oe_n = 1'b0;
      end
      WR_SETUP, WR_HOLD: begin
        st.ce_n  = 1'b0;
        st.dq_oe = 1'b1;
      end
      WR_PULSE: begin
        st.ce_n  = 1'b0;
        st.we_n  = 1'b0;
        st.dq_oe = 1'b1;
      end
      default: ;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Asynchronous SRAM controller: turns single-cycle read/write requests from the
// memory stage into timed SRAM strobe sequences, stalling the pipeline meanwhile.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned READ_CYCLES  = 2,
  parameter int unsigned WRITE_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_access_read,
  input  logic               mem_access_write,
  input  logic [31:0]        mem_access_addr,
  input  logic [31:0]        mem_access_data_o,
  input  logic [3:0]         mem_access_byte_en,
  output logic [31:0]        mem_access_data_i,
  output logic               mem_stall,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [31:0]        sram_dq_i,
  output logic [31:0]        sram_dq_o,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n
);

  localparam logic [3:0] RD_LAST = 4'(READ_CYCLES - 1);
  localparam logic [3:0] WR_LAST = 4'(WRITE_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       accept;
  logic       capture;
  strobe_t    stb_next;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_access_addr[31:22], mem_access_addr[1:0]};

  assign mem_stall = rst_n &&
                     (((state == IDLE) && (mem_access_read || mem_access_write)) ||
                      ((state != IDLE) && (state != DONE)));

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_access_write) begin
          state_next = WR_SETUP;
          accept     = 1'b1;
        end else if (mem_access_read) begin
          state_next = RD;
          accept     = 1'b1;
        end
      end
      RD: begin
        if (cnt == RD_LAST) begin
          state_next = DONE;
          cnt_next   = '0;
          capture    = 1'b1;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      WR_SETUP: state_next = WR_PULSE;
      WR_PULSE: begin
        if (cnt == WR_LAST) begin
          state_next = WR_HOLD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 4'd1;
        end
      end
      WR_HOLD: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are registered from the next state so each pin changes only on a clock edge.
  assign stb_next = strobes_for(state_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      mem_access_data_i <= '0;
      sram_addr         <= '0;
      sram_dq_o         <= '0;
      sram_dq_oe        <= 1'b0;
      sram_ce_n         <= 1'b1;
      sram_oe_n         <= 1'b1;
      sram_we_n         <= 1'b1;
      sram_be_n         <= '1;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      sram_ce_n  <= stb_next.ce_n;
      sram_oe_n  <= stb_next.oe_n;
      sram_we_n  <= stb_next.we_n;
      sram_dq_oe <= stb_next.dq_oe;
      if (accept) begin
        sram_addr <= mem_access_addr[21:2];
        sram_dq_o <= mem_access_data_o;
        sram_be_n <= mem_access_write ? ~mem_access_byte_en : '0;
      end else if (state_next == DONE) begin
        sram_be_n <= '1;
      end
      if (capture) begin
        mem_access_data_i <= sram_dq_i;
      end
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: three instances (cycles 2, 1, 15) share the
// request inputs; instance 0 is backed by a small byte-enabled SRAM model.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        mem_access_read;
  logic        mem_access_write;
  logic [31:0] mem_access_addr;
  logic [31:0] mem_access_data_o;
  logic [3:0]  mem_access_byte_en;

  logic [31:0] data_i_v [3];
  logic        stall_v  [3];
  logic [19:0] addr_v   [3];
  logic [31:0] dq_i_v   [3];
  logic [31:0] dq_o_v   [3];
  logic        dq_oe_v  [3];
  logic        ce_n_v   [3];
  logic        oe_n_v   [3];
  logic        we_n_v   [3];
  logic [3:0]  be_n_v   [3];

  logic [31:0] mem [16];

  int unsigned n_cmp;
  int unsigned n_fail;

  function automatic int unsigned cyc_of(int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 15;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_ctrl #(
      .READ_CYCLES (cyc_of(g)),
      .WRITE_CYCLES(cyc_of(g))
    ) u_dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .mem_access_read   (mem_access_read),
      .mem_access_write  (mem_access_write),
      .mem_access_addr   (mem_access_addr),
      .mem_access_data_o (mem_access_data_o),
      .mem_access_byte_en(mem_access_byte_en),
      .mem_access_data_i (data_i_v[g]),
      .mem_stall         (stall_v[g]),
      .sram_addr         (addr_v[g]),
      .sram_dq_i         (dq_i_v[g]),
      .sram_dq_o         (dq_o_v[g]),
      .sram_dq_oe        (dq_oe_v[g]),
      .sram_ce_n         (ce_n_v[g]),
      .sram_oe_n         (oe_n_v[g]),
      .sram_we_n         (we_n_v[g]),
      .sram_be_n         (be_n_v[g])
    );
    if (g == 0) begin : g_mem
      assign dq_i_v[g] = mem[addr_v[g][3:0]];
    end else begin : g_pat
      assign dq_i_v[g] = {12'hA5A, addr_v[g]};
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model for instance 0, preloaded while reset is held.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[2] <= 32'hAABBCCDD;
      mem[4] <= 32'hDEADBEEF;
      mem[5] <= 32'h0BADF00D;
    end else if (!ce_n_v[0] && !we_n_v[0]) begin
      for (int b = 0; b < 4; b++)
        if (!be_n_v[0][b]) mem[addr_v[0][3:0]][8*b +: 8] <= dq_o_v[0][8*b +: 8];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic settle();
    mem_access_read  = 1'b0;
    mem_access_write = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [9:0] got;
    #1;
    for (int k = 0; k < 3; k++) begin
      got = {stall_v[k], ce_n_v[k], oe_n_v[k], we_n_v[k], dq_oe_v[k], be_n_v[k], 1'b0};
      n_cmp++;
      if (got !== 10'b0_1110_1111_0) begin
        $display("FAIL reset_strobes[%0d]: got %b expected %b", k, got, 10'b0_1110_1111_0);
        n_fail++;
      end
      n_cmp++;
      if ({data_i_v[k], dq_o_v[k], addr_v[k]} !== 84'h0) begin
        $display("FAIL reset_regs[%0d]: got %h/%h/%h expected 0/0/0", k, data_i_v[k], dq_o_v[k], addr_v[k]);
        n_fail++;
      end
    end
  endtask

  task automatic test_read();
    logic [4:0] exp [4];
    exp[0] = 5'b1_1110; exp[1] = 5'b1_0010; exp[2] = 5'b1_0010; exp[3] = 5'b0_1110;
    mem_access_read = 1'b1;
    mem_access_addr = 32'h0000_0010;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if ({stall_v[0], ce_n_v[0], oe_n_v[0], we_n_v[0], dq_oe_v[0]} !== exp[c]) begin
        $display("FAIL read_cycle%0d: got %b expected %b", c,
                 {stall_v[0], ce_n_v[0], oe_n_v[0], we_n_v[0], dq_oe_v[0]}, exp[c]);
        n_fail++;
      end
      if (c == 1) begin
        n_cmp++;
        if ({addr_v[0], be_n_v[0]} !== {20'h00004, 4'b0000}) begin
          $display("FAIL read_addr_be: got %h/%b expected 00004/0000", addr_v[0], be_n_v[0]);
          n_fail++;
        end
      end
      if (c == 3) begin
        n_cmp++;
        if (data_i_v[0] !== 32'hDEADBEEF) begin
          $display("FAIL read_data: got %h expected deadbeef", data_i_v[0]);
          n_fail++;
        end
      end
      @(negedge clk);
      mem_access_read = 1'b0;
    end
    settle();
  endtask

  task automatic test_write();
    logic [4:0] exp [6];
    exp[0] = 5'b1_1110; exp[1] = 5'b1_0111; exp[2] = 5'b1_0101;
    exp[3] = 5'b1_0101; exp[4] = 5'b1_0111; exp[5] = 5'b0_1110;
    mem_access_write   = 1'b1;
    mem_access_addr    = 32'h0000_0008;
    mem_access_data_o  = 32'h12345678;
    mem_access_byte_en = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_cmp++;
      if ({stall_v[0], ce_n_v[0], oe_n_v[0], we_n_v[0], dq_oe_v[0]} !== exp[c]) begin
        $display("FAIL write_cycle%0d: got %b expected %b", c,
                 {stall_v[0], ce_n_v[0], oe_n_v[0], we_n_v[0], dq_oe_v[0]}, exp[c]);
        n_fail++;
      end
      if (c >= 1 && c <= 4) begin
        n_cmp++;
        if ({dq_o_v[0], addr_v[0], be_n_v[0]} !== {32'h12345678, 20'h00002, 4'b1011}) begin
          $display("FAIL write_bus%0d: got %h/%h/%b expected 12345678/00002/1011", c,
                   dq_o_v[0], addr_v[0], be_n_v[0]);
          n_fail++;
        end
      end
      @(negedge clk);
      mem_access_write = 1'b0;
      mem_access_data_o = 32'hFFFF_FFFF;
    end
    n_cmp++;
    if (mem[2] !== 32'hAA34CCDD) begin
      $display("FAIL write_mem: got %h expected aa34ccdd", mem[2]);
      n_fail++;
    end
    n_cmp++;
    if (data_i_v[0] !== 32'hDEADBEEF) begin
      $display("FAIL write_keeps_data_i: got %h expected deadbeef", data_i_v[0]);
      n_fail++;
    end
    settle();
  endtask

  task automatic test_back_to_back();
    logic exp_stall [9];
    int unsigned rd_starts;
    logic prev_oe;
    exp_stall = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    rd_starts = 0;
    prev_oe = 1'b1;
    mem_access_read = 1'b1;
    mem_access_addr = 32'h0000_0010;
    for (int c = 0; c < 9; c++) begin
      #1;
      if (prev_oe && !oe_n_v[0]) rd_starts++;
      prev_oe = oe_n_v[0];
      n_cmp++;
      if (stall_v[0] !== exp_stall[c]) begin
        $display("FAIL b2b_stall%0d: got %b expected %b", c, stall_v[0], exp_stall[c]);
        n_fail++;
      end
      if (c == 3 || c == 7) begin
        n_cmp++;
        if (data_i_v[0] !== ((c == 3) ? 32'hDEADBEEF : 32'h0BADF00D)) begin
          $display("FAIL b2b_data%0d: got %h expected %h", c, data_i_v[0],
                   (c == 3) ? 32'hDEADBEEF : 32'h0BADF00D);
          n_fail++;
        end
      end
      @(negedge clk);
      if (c + 1 == 1) mem_access_addr = 32'h0000_0014;
      if (c + 1 == 8) mem_access_read = 1'b0;
    end
    n_cmp++;
    if (rd_starts != 2) begin
      $display("FAIL b2b_count: got %0d expected 2", rd_starts);
      n_fail++;
    end
    settle();
  endtask

  task automatic measure(input logic rd, input logic wr, input string tag);
    int unsigned oe_lo [3];
    int unsigned we_lo [3];
    int unsigned st_hi [3];
    int unsigned exp_oe, exp_we, exp_st;
    oe_lo = '{0, 0, 0};
    we_lo = '{0, 0, 0};
    st_hi = '{0, 0, 0};
    mem_access_read    = rd;
    mem_access_write   = wr;
    mem_access_addr    = 32'h0000_0040;
    mem_access_data_o  = 32'hCAFE0001;
    mem_access_byte_en = 4'b1111;
    for (int c = 0; c < 40; c++) begin
      #1;
      for (int k = 0; k < 3; k++) begin
        if (!oe_n_v[k]) oe_lo[k]++;
        if (!we_n_v[k]) we_lo[k]++;
        if (stall_v[k]) st_hi[k]++;
      end
      @(negedge clk);
      mem_access_read  = 1'b0;
      mem_access_write = 1'b0;
    end
    for (int k = 0; k < 3; k++) begin
      exp_oe = (rd && !wr) ? cyc_of(k) : 0;
      exp_we = wr ? cyc_of(k) : 0;
      exp_st = wr ? cyc_of(k) + 3 : cyc_of(k) + 1;
      n_cmp++;
      if ({oe_lo[k], we_lo[k], st_hi[k]} !== {exp_oe, exp_we, exp_st}) begin
        $display("FAIL %s_width[%0d]: got oe%0d/we%0d/stall%0d expected oe%0d/we%0d/stall%0d",
                 tag, k, oe_lo[k], we_lo[k], st_hi[k], exp_oe, exp_we, exp_st);
        n_fail++;
      end
    end
    if (rd && !wr) begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (data_i_v[k] !== ((k == 0) ? 32'h0 : 32'hA5A00010)) begin
          $display("FAIL %s_data[%0d]: got %h expected %h", tag, k, data_i_v[k],
                   (k == 0) ? 32'h0 : 32'hA5A00010);
          n_fail++;
        end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    mem_access_write   = 1'b1;
    mem_access_addr    = 32'h0000_000C;
    mem_access_data_o  = 32'h55AA55AA;
    mem_access_byte_en = 4'b1111;
    @(negedge clk);
    mem_access_write = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (we_n_v[0] !== 1'b0) begin
      $display("FAIL rstmid_pulse: got we_n=%b expected 0", we_n_v[0]);
      n_fail++;
    end
    mem_access_write = 1'b1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({we_n_v[0], dq_oe_v[0], stall_v[0], ce_n_v[0]} !== 4'b1001) begin
      $display("FAIL rstmid_strobes: got %b expected 1001",
               {we_n_v[0], dq_oe_v[0], stall_v[0], ce_n_v[0]});
      n_fail++;
    end
    n_cmp++;
    if (g_dut[0].u_dut.state !== IDLE) begin
      $display("FAIL rstmid_state: got %0d expected %0d", g_dut[0].u_dut.state, IDLE);
      n_fail++;
    end
    @(negedge clk);
    mem_access_write = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n              = 1'b0;
    mem_access_read    = 1'b1;
    mem_access_write   = 1'b1;
    mem_access_addr    = 32'hFFFF_FFFF;
    mem_access_data_o  = 32'hFFFF_FFFF;
    mem_access_byte_en = 4'b1111;
    repeat (2) @(negedge clk);
    test_reset();
    mem_access_read  = 1'b0;
    mem_access_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_read();
    test_write();
    test_back_to_back();
    measure(1'b1, 1'b0, "rd");
    measure(1'b0, 1'b1, "wr");
    measure(1'b1, 1'b1, "both");
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
